// File: rtl/data_link_pkg.sv
// Shared definitions for the BPSK packet link (transmitter and receiver).
package data_link_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } rx_state_e;

  localparam int          SYNC_SIZE_DEF = 8;
  localparam logic [31:0] SYNC_WORD_DEF = 32'h0000_00D5;
  localparam int          IDX_W         = 8;

endpackage

// File: rtl/sync_detect.sv
// Sync-word hunter: shift register of the incoming bits with a look-ahead
// equality compare on the value the register is about to take.
module sync_detect #(
  parameter int          SYNC_SIZE = data_link_pkg::SYNC_SIZE_DEF,
  parameter logic [31:0] SYNC_WORD = data_link_pkg::SYNC_WORD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic clear,
  input  logic bit_in,
  output logic match
);

  localparam logic [SYNC_SIZE-1:0] SYNC_PAT = SYNC_WORD[SYNC_SIZE-1:0];

  logic [SYNC_SIZE-1:0] sync_sr;
  logic [SYNC_SIZE-1:0] sync_base;
  logic [SYNC_SIZE-1:0] sync_nxt;

  // A clear coinciding with a shift restarts the hunt from this bit.
  assign sync_base = clear ? '0 : sync_sr;
  assign sync_nxt  = (sync_base << 1) | SYNC_SIZE'(bit_in);
  assign match     = shift_en && (sync_nxt == SYNC_PAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr <= '0;
    end else if (shift_en) begin
      sync_sr <= sync_nxt;
    end else if (clear) begin
      sync_sr <= '0;
    end
  end

endmodule

// File: rtl/data_receive.sv
// Packet receiver: hunts for the sync word, then assembles PACKET_SIZE bits
// into a parallel packet delivered over a valid/ready handshake.
//
// state   | meaning
// HUNT    | shifting bits through sync_detect, waiting for a match
// COLLECT | writing payload bits into packet[idx]
// DONE    | packet_valid high, packet frozen, waiting for packet_ready
module data_receive
  import data_link_pkg::*;
#(
  parameter int          PACKET_SIZE = 32,
  parameter int          SYNC_SIZE   = SYNC_SIZE_DEF,
  parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 packet_ready,
  output logic [0:PACKET_SIZE-1] packet,
  output logic                 packet_valid,
  output logic                 sync_found,
  output logic                 overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_SIZE - 1);

  rx_state_e        state;
  logic [IDX_W-1:0] idx;
  logic             handshake;
  logic             sync_shift;
  logic             sync_match;

  assign handshake  = (state == DONE) && packet_valid && packet_ready;
  assign sync_shift = bit_valid && ((state == HUNT) || handshake);

  sync_detect #(
    .SYNC_SIZE (SYNC_SIZE),
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (sync_shift),
    .clear    (handshake),
    .bit_in   (bit_in),
    .match    (sync_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      idx          <= '0;
      packet       <= '0;
      packet_valid <= 1'b0;
      sync_found   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sync_found <= 1'b0;
      case (state)
        HUNT: begin
          if (bit_valid && sync_match) begin
            state      <= COLLECT;
            idx        <= '0;
            sync_found <= 1'b1;
          end
        end
        COLLECT: begin
          if (bit_valid) begin
            for (int i = 0; i < PACKET_SIZE; i++) begin
              if (idx == IDX_W'(i)) packet[i] <= bit_in;
            end
            idx <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              state        <= DONE;
              packet_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // A bit arriving with the handshake is taken by sync_detect, not dropped.
          if (handshake) begin
            state        <= HUNT;
            packet_valid <= 1'b0;
            overrun      <= 1'b0;
          end else if (bit_valid) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state        <= HUNT;
          packet_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_receive.sv
// Directed bench for data_receive: an 8-bit-packet instance with the default
// sync word, plus a 1-bit packet / 1-bit sync corner instance.
module tb_data_receive;

  logic       clk;
  logic       rst_n;
  logic       bit_in, bit_valid, packet_ready;
  logic [0:7] packet;
  logic       packet_valid, sync_found, overrun;

  logic       bit_in1, bit_valid1, packet_ready1;
  logic [0:0] packet1;
  logic       packet_valid1, sync_found1, overrun1;

  int vecs;
  int errs;

  data_receive #(.PACKET_SIZE(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .packet_ready (packet_ready),
    .packet       (packet),
    .packet_valid (packet_valid),
    .sync_found   (sync_found),
    .overrun      (overrun)
  );

  data_receive #(.PACKET_SIZE(1), .SYNC_SIZE(1), .SYNC_WORD(32'd1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_in       (bit_in1),
    .bit_valid    (bit_valid1),
    .packet_ready (packet_ready1),
    .packet       (packet1),
    .packet_valid (packet_valid1),
    .sync_found   (sync_found1),
    .overrun      (overrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle with a bit strobe; outputs are sampled 1ns after the edge.
  task automatic bit_cycle(input logic b, input logic rdy);
    @(negedge clk);
    bit_valid    = 1'b1;
    bit_in       = b;
    packet_ready = rdy;
    @(posedge clk);
    #1;
    bit_valid    = 1'b0;
    packet_ready = 1'b0;
  endtask

  task automatic idle_cycle(input logic rdy);
    @(negedge clk);
    bit_valid    = 1'b0;
    packet_ready = rdy;
    @(posedge clk);
    #1;
    packet_ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], rdy);
  endtask

  task automatic bit_cycle1(input logic b, input logic rdy);
    @(negedge clk);
    bit_valid1    = 1'b1;
    bit_in1       = b;
    packet_ready1 = rdy;
    @(posedge clk);
    #1;
    bit_valid1    = 1'b0;
    packet_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    vecs++; if (packet !== 8'h00) begin errs++; $display("FAIL reset_packet got %b exp %b", packet, 8'h00); end
    vecs++; if (packet_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", packet_valid); end
    vecs++; if (sync_found !== 1'b0) begin errs++; $display("FAIL reset_sync got %b exp 0", sync_found); end
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun got %b exp 0", overrun); end
  endtask

  task automatic test_basic();
    logic [7:0] sw;
    logic [7:0] pl;
    int pulses;
    sw = 8'b1101_0101;
    pl = 8'b1011_0010;
    pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(sw[i], 1'b1);
      if (sync_found === 1'b1) pulses++;
    end
    vecs++; if (sync_found !== 1'b1) begin errs++; $display("FAIL basic_sync_latency got %b exp 1", sync_found); end
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(pl[i], 1'b1);
      if (sync_found === 1'b1) pulses++;
      if (i == 7) begin
        vecs++; if (sync_found !== 1'b0) begin errs++; $display("FAIL basic_sync_width got %b exp 0", sync_found); end
      end
      if (i == 1) begin
        vecs++; if (packet_valid !== 1'b0) begin errs++; $display("FAIL basic_valid_early got %b exp 0", packet_valid); end
      end
    end
    vecs++; if (pulses != 1) begin errs++; $display("FAIL basic_sync_pulses got %0d exp 1", pulses); end
    vecs++; if (packet_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %b exp 1", packet_valid); end
    vecs++; if (packet !== 8'b1011_0010) begin errs++; $display("FAIL basic_packet got %b exp %b", packet, 8'b1011_0010); end
    vecs++; if (packet[0] !== 1'b1) begin errs++; $display("FAIL basic_packet0 got %b exp 1", packet[0]); end
    idle_cycle(1'b1);
    vecs++; if (packet_valid !== 1'b0) begin errs++; $display("FAIL basic_valid_width got %b exp 0", packet_valid); end
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL basic_overrun got %b exp 0", overrun); end
    vecs++; if (packet !== 8'b1011_0010) begin errs++; $display("FAIL basic_packet_hold got %b exp %b", packet, 8'b1011_0010); end
  endtask

  task automatic test_false_sync();
    logic [8:0] seq;
    logic [7:0] pl;
    seq = 9'b0_1101_0101;
    pl  = 8'hD5;
    for (int i = 8; i >= 0; i--) begin
      bit_cycle(seq[i], 1'b0);
      if (i > 0) begin
        vecs++; if (sync_found !== 1'b0) begin errs++; $display("FAIL false_sync_early bit %0d got %b exp 0", 8 - i, sync_found); end
      end
    end
    vecs++; if (sync_found !== 1'b1) begin errs++; $display("FAIL false_sync_ninth got %b exp 1", sync_found); end
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(pl[i], 1'b0);
      vecs++; if (sync_found !== 1'b0) begin errs++; $display("FAIL false_sync_payload bit %0d got %b exp 0", 7 - i, sync_found); end
    end
    vecs++; if (packet !== 8'hD5) begin errs++; $display("FAIL false_sync_packet got %b exp %b", packet, 8'hD5); end
    idle_cycle(1'b1);
  endtask

  task automatic test_backpressure();
    send_byte(8'hD5, 1'b0);
    send_byte(8'b0110_0111, 1'b0);
    vecs++; if (packet_valid !== 1'b1) begin errs++; $display("FAIL bp_valid got %b exp 1", packet_valid); end
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL bp_overrun_pre got %b exp 0", overrun); end
    for (int i = 0; i < 3; i++) bit_cycle(1'b1, 1'b0);
    vecs++; if (packet !== 8'b0110_0111) begin errs++; $display("FAIL bp_packet got %b exp %b", packet, 8'b0110_0111); end
    vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL bp_overrun got %b exp 1", overrun); end
    vecs++; if (packet_valid !== 1'b1) begin errs++; $display("FAIL bp_valid_hold got %b exp 1", packet_valid); end
    idle_cycle(1'b0);
    vecs++; if (packet_valid !== 1'b1) begin errs++; $display("FAIL bp_valid_noready got %b exp 1", packet_valid); end
    idle_cycle(1'b1);
    vecs++; if (packet_valid !== 1'b0) begin errs++; $display("FAIL bp_valid_fall got %b exp 0", packet_valid); end
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL bp_overrun_clear got %b exp 0", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] rest;
    rest = 7'b101_0101;
    send_byte(8'hD5, 1'b0);
    send_byte(8'h3C, 1'b0);
    bit_cycle(1'b0, 1'b0);
    vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL simul_overrun_set got %b exp 1", overrun); end
    bit_cycle(1'b1, 1'b1);
    vecs++; if (packet_valid !== 1'b0) begin errs++; $display("FAIL simul_valid got %b exp 0", packet_valid); end
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL simul_overrun got %b exp 0", overrun); end
    for (int i = 6; i >= 0; i--) begin
      bit_cycle(rest[i], 1'b0);
      if (i > 0) begin
        vecs++; if (sync_found !== 1'b0) begin errs++; $display("FAIL simul_sync_early bit %0d got %b exp 0", 7 - i, sync_found); end
      end
    end
    vecs++; if (sync_found !== 1'b1) begin errs++; $display("FAIL simul_sync got %b exp 1", sync_found); end
    send_byte(8'hA6, 1'b0);
    vecs++; if (packet !== 8'hA6) begin errs++; $display("FAIL simul_packet got %b exp %b", packet, 8'hA6); end
    idle_cycle(1'b1);
  endtask

  task automatic test_reset_mid();
    send_byte(8'hD5, 1'b0);
    for (int i = 0; i < 4; i++) bit_cycle(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++; if (packet !== 8'h00) begin errs++; $display("FAIL midrst_packet got %b exp %b", packet, 8'h00); end
    vecs++; if (packet_valid !== 1'b0) begin errs++; $display("FAIL midrst_valid got %b exp 0", packet_valid); end
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL midrst_overrun got %b exp 0", overrun); end
    @(negedge clk);
    rst_n = 1'b1;
    bit_cycle(1'b1, 1'b0);
    vecs++; if (packet_valid !== 1'b0) begin errs++; $display("FAIL midrst_no_resume got %b exp 0", packet_valid); end
    send_byte(8'hD5, 1'b0);
    send_byte(8'h5B, 1'b0);
    vecs++; if (packet_valid !== 1'b1) begin errs++; $display("FAIL midrst_valid_after got %b exp 1", packet_valid); end
    vecs++; if (packet !== 8'h5B) begin errs++; $display("FAIL midrst_packet_after got %b exp %b", packet, 8'h5B); end
    idle_cycle(1'b1);
  endtask

  task automatic test_corner();
    bit_cycle1(1'b0, 1'b0);
    vecs++; if (sync_found1 !== 1'b0) begin errs++; $display("FAIL corner_sync_bit1 got %b exp 0", sync_found1); end
    bit_cycle1(1'b1, 1'b0);
    vecs++; if (sync_found1 !== 1'b1) begin errs++; $display("FAIL corner_sync_bit2 got %b exp 1", sync_found1); end
    vecs++; if (packet_valid1 !== 1'b0) begin errs++; $display("FAIL corner_valid_bit2 got %b exp 0", packet_valid1); end
    bit_cycle1(1'b1, 1'b0);
    vecs++; if (packet_valid1 !== 1'b1) begin errs++; $display("FAIL corner_valid got %b exp 1", packet_valid1); end
    vecs++; if (packet1 !== 1'b1) begin errs++; $display("FAIL corner_packet got %b exp 1", packet1); end
    vecs++; if (sync_found1 !== 1'b0) begin errs++; $display("FAIL corner_sync_width got %b exp 0", sync_found1); end
  endtask

  initial begin
    vecs          = 0;
    errs          = 0;
    rst_n         = 1'b0;
    bit_in        = 1'b0;
    bit_valid     = 1'b0;
    packet_ready  = 1'b0;
    bit_in1       = 1'b0;
    bit_valid1    = 1'b0;
    packet_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_false_sync();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_corner();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
